// File: rtl/bp_cce_mem_mux_pkg.sv
// Package for the multi-slice CCE-MEM merge block.
// Holds a width helper shared by the mux top and its tag FIFO; message
// contents are treated as opaque bits, so no message typedefs live here.
package bp_cce_mem_mux_pkg;

    // Width of an index/counter for n states, never less than one bit.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bp_me_tag_fifo.sv
// Tag FIFO: records which slice issued each in-flight memory command.
// Circular buffer with wrap-around read/write pointers plus an occupancy count.
// Ports:
//   clk_i, reset_n_i     clock, asynchronous active-low reset
//   push_i, data_i       enqueue a tag (ignored when full)
//   pop_i                dequeue the head tag (ignored when empty)
//   head_o               oldest tag
//   full_o, empty_o      occupancy flags
//   count_o              number of stored tags
module bp_me_tag_fifo
    import bp_cce_mem_mux_pkg::*;
#(
    parameter int width_p = 2,
    parameter int depth_p = 8,
    localparam int ptr_w_lp = safe_clog2(depth_p),
    localparam int cnt_w_lp = safe_clog2(depth_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                push_i,
    input  logic [width_p-1:0]  data_i,
    input  logic                pop_i,
    output logic [width_p-1:0]  head_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [cnt_w_lp-1:0] count_o
);

    localparam logic [ptr_w_lp-1:0] last_lp  = ptr_w_lp'(depth_p - 1);
    localparam logic [cnt_w_lp-1:0] depth_lp = cnt_w_lp'(depth_p);

    logic [width_p-1:0]  mem_q [depth_p];
    logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
    logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic                push_ok, pop_ok;

    assign full_o  = (count_q == depth_lp);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == last_lp) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == last_lp) ? '0 : rd_ptr_q + 1'b1;
        end
        // Simultaneous push and pop leaves the count unchanged.
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage carries no reset; validity comes from the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bp_cce_mem_mux.sv
// Merges the CCE-MEM command streams of num_cce_p CCE slices onto a single
// memory port and steers the in-order memory responses back to their issuer.
// Ports:
//   clk_i, reset_n_i                 clock, asynchronous active-low reset
//   cce_cmd_i/_v_i/_ready_o          per-slice commands, slice i at [i*msg_width_p +: msg_width_p]
//   mem_cmd_o/_v_o, mem_cmd_ready_i  merged command toward memory
//   mem_resp_i/_v_i/_yumi_o          in-order memory responses
//   cce_resp_o, cce_resp_v_o         response broadcast, one-hot valid to the owning slice
//   cce_resp_yumi_i                  per-slice consume
//   outstanding_o                    commands issued whose response is not yet consumed
module bp_cce_mem_mux
    import bp_cce_mem_mux_pkg::*;
#(
    parameter int num_cce_p         = 4,
    parameter int msg_width_p       = 128,
    parameter int max_outstanding_p = 8,
    parameter int fixed_priority_p  = 0,
    localparam int lg_num_cce_lp     = safe_clog2(num_cce_p),
    localparam int lg_outstanding_lp = safe_clog2(max_outstanding_p + 1)
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_cce_p*msg_width_p-1:0] cce_cmd_i,
    input  logic [num_cce_p-1:0]             cce_cmd_v_i,
    output logic [num_cce_p-1:0]             cce_cmd_ready_o,
    output logic [msg_width_p-1:0]           mem_cmd_o,
    output logic                             mem_cmd_v_o,
    input  logic                             mem_cmd_ready_i,
    input  logic [msg_width_p-1:0]           mem_resp_i,
    input  logic                             mem_resp_v_i,
    output logic                             mem_resp_yumi_o,
    output logic [msg_width_p-1:0]           cce_resp_o,
    output logic [num_cce_p-1:0]             cce_resp_v_o,
    input  logic [num_cce_p-1:0]             cce_resp_yumi_i,
    output logic [lg_outstanding_lp-1:0]     outstanding_o
);

    logic [num_cce_p-1:0]     full_q, full_d;
    logic [msg_width_p-1:0]   buf_q [num_cce_p];
    logic [msg_width_p-1:0]   buf_d [num_cce_p];
    logic [lg_num_cce_lp-1:0] ptr_q, ptr_d;
    logic [lg_num_cce_lp-1:0] grant, rr_idx;
    logic                     rr_found;
    logic [num_cce_p-1:0]     load;
    logic                     any_full, xfer;
    logic                     tag_full, tag_empty, resp_ok;
    logic [lg_num_cce_lp-1:0] tag_head;
    logic [num_cce_p-1:0]     head_oh;

    assign any_full = |full_q;

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign cce_cmd_ready_o = ~full_q & {num_cce_p{reset_n_i}};
    assign load            = cce_cmd_v_i & cce_cmd_ready_o;

    // Arbiter: round-robin scans from ptr+1 and wraps; fixed picks lowest full index.
    always_comb begin
        grant    = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        if (fixed_priority_p != 0) begin
            for (int i = num_cce_p - 1; i >= 0; i--) begin
                if (full_q[i]) begin
                    grant = lg_num_cce_lp'(i);
                end
            end
        end else begin
            for (int k = 1; k <= num_cce_p; k++) begin
                rr_idx = lg_num_cce_lp'((int'(ptr_q) + k) % num_cce_p);
                if (!rr_found && full_q[rr_idx]) begin
                    grant    = rr_idx;
                    rr_found = 1'b1;
                end
            end
        end
    end

    // tag_full uses the registered count, so a same-cycle pop cannot enable
    // issue; this keeps mem_resp -> mem_cmd free of a combinational path.
    assign mem_cmd_v_o = mem_cmd_ready_i & any_full & ~tag_full;
    assign mem_cmd_o   = any_full ? buf_q[grant] : '0;
    assign xfer        = mem_cmd_v_o;

    // A granted buffer was not ready this cycle, so it cannot reload until next cycle.
    always_comb begin
        full_d = full_q;
        ptr_d  = ptr_q;
        buf_d  = buf_q;
        if (xfer) begin
            full_d[grant] = 1'b0;
            if (fixed_priority_p == 0) begin
                ptr_d = grant;
            end
        end
        for (int i = 0; i < num_cce_p; i++) begin
            if (load[i]) begin
                full_d[i] = 1'b1;
                buf_d[i]  = cce_cmd_i[i*msg_width_p +: msg_width_p];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            full_q <= '0;
            ptr_q  <= lg_num_cce_lp'(num_cce_p - 1);
        end else begin
            full_q <= full_d;
            ptr_q  <= ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        buf_q <= buf_d;
    end

    bp_me_tag_fifo #(
        .width_p (lg_num_cce_lp),
        .depth_p (max_outstanding_p)
    ) tag_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (xfer),
        .data_i    (grant),
        .pop_i     (mem_resp_yumi_o),
        .head_o    (tag_head),
        .full_o    (tag_full),
        .empty_o   (tag_empty),
        .count_o   (outstanding_o)
    );

    // Response steering: responses return in issue order, so the head tag owns it.
    assign resp_ok = mem_resp_v_i & ~tag_empty;

    always_comb begin
        head_oh           = '0;
        head_oh[tag_head] = 1'b1;
    end

    assign cce_resp_v_o    = head_oh & {num_cce_p{resp_ok}};
    assign mem_resp_yumi_o = resp_ok & cce_resp_yumi_i[tag_head];
    assign cce_resp_o      = reset_n_i ? mem_resp_i : '0;

    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(mem_resp_v_i && tag_empty))
                else $warning("bp_cce_mem_mux: memory response with no command outstanding");
            assert (tag_empty || ((cce_resp_yumi_i & ~head_oh) == '0))
                else $warning("bp_cce_mem_mux: response consume from a non-owning slice ignored");
        end
    end

endmodule

// File: tb/tb_bp_cce_mem_mux.sv
module tb_bp_cce_mem_mux;

    localparam int N  = 4;
    localparam int W  = 128;
    localparam int MO = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n_i;
    logic [N*W-1:0] cce_cmd_i;
    logic [N-1:0]   cce_cmd_v_i, cce_cmd_ready_o;
    logic [W-1:0]   mem_cmd_o;
    logic           mem_cmd_v_o, mem_cmd_ready_i;
    logic [W-1:0]   mem_resp_i;
    logic           mem_resp_v_i, mem_resp_yumi_o;
    logic [W-1:0]   cce_resp_o;
    logic [N-1:0]   cce_resp_v_o, cce_resp_yumi_i;
    logic [1:0]     outstanding_o;

    // Second instance in fixed-priority mode, directed stimulus only.
    logic [N*W-1:0] fp_cmd_i;
    logic [N-1:0]   fp_cmd_v_i, fp_cmd_ready_o;
    logic [W-1:0]   fp_mem_cmd_o;
    logic           fp_mem_cmd_v_o, fp_mem_cmd_ready_i;
    logic           fp_mem_resp_v_i, fp_mem_resp_yumi_o;
    logic [W-1:0]   fp_cce_resp_o;
    logic [N-1:0]   fp_cce_resp_v_o, fp_cce_resp_yumi_i;
    logic [1:0]     fp_outstanding_o;

    assign fp_mem_resp_v_i    = (fp_outstanding_o != 2'd0);
    assign fp_cce_resp_yumi_i = fp_cce_resp_v_o;

    bp_cce_mem_mux #(.num_cce_p(N), .msg_width_p(W), .max_outstanding_p(MO), .fixed_priority_p(0)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .cce_cmd_i(cce_cmd_i), .cce_cmd_v_i(cce_cmd_v_i), .cce_cmd_ready_o(cce_cmd_ready_o),
        .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
        .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o),
        .cce_resp_o(cce_resp_o), .cce_resp_v_o(cce_resp_v_o), .cce_resp_yumi_i(cce_resp_yumi_i),
        .outstanding_o(outstanding_o)
    );

    bp_cce_mem_mux #(.num_cce_p(N), .msg_width_p(W), .max_outstanding_p(MO), .fixed_priority_p(1)) dut_fp (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .cce_cmd_i(fp_cmd_i), .cce_cmd_v_i(fp_cmd_v_i), .cce_cmd_ready_o(fp_cmd_ready_o),
        .mem_cmd_o(fp_mem_cmd_o), .mem_cmd_v_o(fp_mem_cmd_v_o), .mem_cmd_ready_i(fp_mem_cmd_ready_i),
        .mem_resp_i('0), .mem_resp_v_i(fp_mem_resp_v_i), .mem_resp_yumi_o(fp_mem_resp_yumi_o),
        .cce_resp_o(fp_cce_resp_o), .cce_resp_v_o(fp_cce_resp_v_o), .cce_resp_yumi_i(fp_cce_resp_yumi_i),
        .outstanding_o(fp_outstanding_o)
    );

    typedef struct packed {
        logic [N-1:0] v;
        logic [W-1:0] d;
        logic         y;
    } resp_t;

    // Reference model state: slice buffers, rr pointer, tags of in-flight commands.
    bit           m_full [N];
    logic [W-1:0] m_data [N];
    int           m_ptr;
    int           m_tags [$];

    logic [W-1:0] exp_cmd_q [$];
    resp_t        exp_resp_q [$];
    logic [N-1:0] exp_ready;
    int           exp_outst;
    logic [W-1:0] issued_log [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_evt(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [W-1:0] rnd_w();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // rmode: 0 no response, 1 response consumed by owner, 2 response not consumed,
    // 3 response valid regardless of outstanding, every slice consuming.
    task automatic cyc(input logic [N-1:0] v, input logic [W-1:0] base, input logic mrdy, input int rmode);
        @(negedge clk);
        cce_cmd_v_i = v;
        for (int i = 0; i < N; i++) cce_cmd_i[i*W +: W] = base + W'(i);
        mem_cmd_ready_i = mrdy;
        mem_resp_i      = rnd_w();
        mem_resp_v_i    = 1'b0;
        cce_resp_yumi_i = '0;
        case (rmode)
            1: if (m_tags.size() > 0) begin
                   mem_resp_v_i    = 1'b1;
                   cce_resp_yumi_i = N'(1) << m_tags[0];
               end
            2: if (m_tags.size() > 0) mem_resp_v_i = 1'b1;
            3: begin
                   mem_resp_v_i    = 1'b1;
                   cce_resp_yumi_i = '1;
               end
            default: ;
        endcase
    endtask

    // Model: predicts this cycle's transfers from the rules, then advances.
    always @(negedge clk) begin
        int    w;
        int    idx;
        bit    pop;
        resp_t r;
        #1;
        if (!reset_n_i) begin
            for (int i = 0; i < N; i++) m_full[i] = 1'b0;
            m_ptr = N - 1;
            m_tags.delete();
        end else begin
            exp_outst = m_tags.size();
            for (int i = 0; i < N; i++) exp_ready[i] = !m_full[i];
            pop = 1'b0;
            if (mem_resp_v_i && m_tags.size() > 0) begin
                r.v = N'(1) << m_tags[0];
                r.d = mem_resp_i;
                r.y = cce_resp_yumi_i[m_tags[0]];
                exp_resp_q.push_back(r);
                pop = r.y;
            end
            w = -1;
            if (mem_cmd_ready_i && m_tags.size() < MO) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (w < 0 && m_full[idx]) w = idx;
                end
            end
            if (w >= 0) begin
                exp_cmd_q.push_back(m_data[w]);
                m_full[w] = 1'b0;
                m_ptr     = w;
            end
            for (int i = 0; i < N; i++) begin
                if (cce_cmd_v_i[i] && exp_ready[i]) begin
                    m_full[i] = 1'b1;
                    m_data[i] = cce_cmd_i[i*W +: W];
                end
            end
            if (pop) void'(m_tags.pop_front());
            if (w >= 0) m_tags.push_back(w);
        end
    end

    // Monitor: pops expectations whenever the DUT presents a transfer.
    always @(negedge clk) begin
        logic [W-1:0] ec;
        resp_t        er, ar;
        #2;
        if (!reset_n_i) begin
            chk("reset_outputs",
                256'({cce_cmd_ready_o, mem_cmd_v_o, mem_resp_yumi_o, cce_resp_v_o, outstanding_o,
                      |mem_cmd_o, |cce_resp_o}), 256'(0));
        end else begin
            chk("cmd_ready", 256'(cce_cmd_ready_o), 256'(exp_ready));
            chk("outstanding", 256'(outstanding_o), 256'(exp_outst));
            if (mem_cmd_v_o) begin
                issued_log.push_back(mem_cmd_o);
                if (exp_cmd_q.size() == 0) fail_evt("mem_cmd unexpected");
                else begin
                    ec = exp_cmd_q.pop_front();
                    chk("mem_cmd", 256'(mem_cmd_o), 256'(ec));
                end
            end
            if (exp_cmd_q.size() != 0) begin
                fail_evt("mem_cmd missing");
                exp_cmd_q.delete();
            end
            if (cce_resp_v_o != '0) begin
                ar.v = cce_resp_v_o;
                ar.d = cce_resp_o;
                ar.y = mem_resp_yumi_o;
                if (exp_resp_q.size() == 0) fail_evt("cce_resp unexpected");
                else begin
                    er = exp_resp_q.pop_front();
                    chk("cce_resp", 256'(ar), 256'(er));
                end
            end else if (mem_resp_yumi_o) begin
                fail_evt("mem_resp_yumi without valid");
            end
            if (exp_resp_q.size() != 0) begin
                fail_evt("cce_resp missing");
                exp_resp_q.delete();
            end
        end
    end

    initial begin
        reset_n_i          = 1'b0;
        cce_cmd_i          = '0;
        cce_cmd_v_i        = '0;
        mem_cmd_ready_i    = 1'b0;
        mem_resp_i         = '0;
        mem_resp_v_i       = 1'b0;
        cce_resp_yumi_i    = '0;
        fp_cmd_i           = '0;
        fp_cmd_v_i         = '0;
        fp_mem_cmd_ready_i = 1'b0;

        // Reset with random inputs
        repeat (3) begin
            cyc(N'($urandom), rnd_w(), 1'b1, 3);
            fp_cmd_v_i = N'($urandom);
        end
        #2;
        chk("rst_ready", 256'(cce_cmd_ready_o), 256'(0));
        chk("rst_fp_ready", 256'(fp_cmd_ready_o), 256'(0));
        cyc('0, '0, 1'b0, 0);
        reset_n_i  = 1'b1;
        fp_cmd_v_i = '0;
        #2;
        chk("rel_ready", 256'(cce_cmd_ready_o), 256'(4'b1111));
        chk("rel_outstanding", 256'(outstanding_o), 256'(0));

        // Round-robin order
        issued_log.delete();
        cyc(4'b1111, W'('hA0), 1'b1, 0);
        #2;
        chk("rr_load_cycle_v", 256'(mem_cmd_v_o), 256'(0));
        repeat (4) cyc('0, '0, 1'b1, 1);
        #3;
        chk("rr_count", 256'(issued_log.size()), 256'(4));
        for (int i = 0; i < 4 && i < issued_log.size(); i++)
            chk("rr_order", 256'(issued_log[i]), 256'('hA0 + i));
        repeat (3) cyc('0, '0, 1'b0, 1);

        // Tag full: slices 2 then 0 issue, slice 1 waits
        cyc(4'b0100, W'('hD0), 1'b1, 0);
        cyc(4'b0001, W'('hD0), 1'b1, 0);
        cyc(4'b0010, W'('hD0), 1'b1, 0);
        cyc('0, '0, 1'b1, 0);
        #2;
        chk("tagfull_v", 256'(mem_cmd_v_o), 256'(0));
        chk("tagfull_outstanding", 256'(outstanding_o), 256'(2));
        cyc('0, '0, 1'b1, 2);
        #2;
        chk("steer_first", 256'(cce_resp_v_o), 256'(4'b0100));
        chk("hold_yumi", 256'(mem_resp_yumi_o), 256'(0));
        cyc('0, '0, 1'b1, 2);
        #2;
        chk("retain_tag", 256'(cce_resp_v_o), 256'(4'b0100));
        chk("retain_outstanding", 256'(outstanding_o), 256'(2));
        cyc('0, '0, 1'b1, 1);
        #2;
        chk("pop_same_cycle_blocks", 256'(mem_cmd_v_o), 256'(0));
        cyc('0, '0, 1'b1, 2);
        #2;
        chk("steer_second", 256'(cce_resp_v_o), 256'(4'b0001));
        chk("slice1_issue_v", 256'(mem_cmd_v_o), 256'(1));
        chk("slice1_issue_d", 256'(mem_cmd_o), 256'('hD1));
        repeat (3) cyc('0, '0, 1'b0, 1);

        // Response with nothing outstanding
        cyc('0, '0, 1'b0, 3);
        #2;
        chk("err_yumi", 256'(mem_resp_yumi_o), 256'(0));
        chk("err_valid", 256'(cce_resp_v_o), 256'(0));

        // Fixed priority on the second instance
        cyc('0, '0, 1'b0, 0);
        fp_cmd_v_i           = 4'b1010;
        fp_cmd_i[1*W +: W]   = W'('hB1);
        fp_cmd_i[3*W +: W]   = W'('hB3);
        fp_mem_cmd_ready_i   = 1'b0;
        #2;
        chk("fp_not_ready_v", 256'(fp_mem_cmd_v_o), 256'(0));
        cyc('0, '0, 1'b0, 0);
        fp_cmd_v_i         = '0;
        fp_mem_cmd_ready_i = 1'b1;
        #2;
        chk("fp_first_v", 256'(fp_mem_cmd_v_o), 256'(1));
        chk("fp_first_d", 256'(fp_mem_cmd_o), 256'('hB1));
        cyc('0, '0, 1'b0, 0);
        fp_cmd_v_i         = 4'b0010;
        fp_cmd_i[1*W +: W] = W'('hC1);
        #2;
        chk("fp_second_d", 256'(fp_mem_cmd_o), 256'('hB3));
        chk("fp_resp_yumi", 256'(fp_mem_resp_yumi_o), 256'(1));
        chk("fp_resp_data", 256'(fp_cce_resp_o), 256'(0));
        cyc('0, '0, 1'b0, 0);
        fp_cmd_v_i = '0;
        #2;
        chk("fp_third_d", 256'(fp_mem_cmd_o), 256'('hC1));
        cyc('0, '0, 1'b0, 0);
        fp_mem_cmd_ready_i = 1'b0;

        // Reset mid-burst with two outstanding
        cyc(4'b1111, W'('hE0), 1'b0, 0);
        repeat (3) cyc('0, '0, 1'b1, 0);
        #2;
        chk("burst_outstanding", 256'(outstanding_o), 256'(2));
        cyc('0, '0, 1'b0, 0);
        reset_n_i = 1'b0;
        #2;
        chk("midrst_outstanding", 256'(outstanding_o), 256'(0));
        cyc('0, '0, 1'b0, 0);
        reset_n_i = 1'b1;
        #2;
        chk("midrst_ready", 256'(cce_cmd_ready_o), 256'(4'b1111));
        chk("midrst_cmd_v", 256'(mem_cmd_v_o), 256'(0));

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(N'($urandom), '0, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 2)));
            for (int i = 0; i < N; i++) cce_cmd_i[i*W +: W] = rnd_w();
        end
        repeat (6) cyc('0, '0, 1'b0, 1);
        @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
